// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, mode constants and helpers for the multi-slave SPI master
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_t;

  // {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // A divider of zero would never tick, so it runs as the fastest legal rate.
  function automatic logic [31:0] spi_eff_half(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - half-period tick generator, one-cycle pulse every half clk cycles
module spi_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] half,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == half - DIV_W'(1));

  // Held at zero while disabled so every enable rise starts a fresh period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - SPI master with configurable width, mode, bit order and chip selects
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 16,
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  div_factor,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              avail,
  output logic              err
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EW    = $clog2(EDGES + 1);

  spi_state_t        state, state_nx;
  logic              cpol_q, cpha_q, lsb_q;
  logic [DIV_W-1:0]  half_q;
  logic [DATA_W-1:0] tx_sr, rx_sr, tx_word;
  logic [EW-1:0]     edge_cnt;
  logic              tick, idle_ok, cs_bad, accept, shifting;
  logic              leading, last_edge, do_sample, do_drive, done;

  function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = w[DATA_W-1-i];
    return r;
  endfunction

  // The completion cycle is IDLE but must not accept; avail marks exactly that cycle.
  assign idle_ok   = start && (state == ST_IDLE) && !avail;
  assign cs_bad    = int'(cs_sel) >= NUM_CS;
  assign accept    = idle_ok && !cs_bad;
  // LSB-first words are reversed once so the shifters always work MSB-first.
  assign tx_word   = lsb_first ? rev(data_in) : data_in;
  assign shifting  = (state == ST_LEAD) || (state == ST_XFER);
  assign leading   = !edge_cnt[0];
  assign last_edge = (edge_cnt == EW'(EDGES - 1));
  assign do_sample = tick && shifting && (leading ^ cpha_q);
  assign do_drive  = tick && shifting &&
                     (cpha_q ? leading : (!leading && !last_edge));
  assign done      = tick && (state == ST_TRAIL);

  spi_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state != ST_IDLE),
    .half  (half_q),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_LEAD;
      ST_LEAD:  if (tick) state_nx = ST_XFER;
      ST_XFER:  if (tick && last_edge) state_nx = ST_TRAIL;
      ST_TRAIL: if (tick) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      half_q   <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      data_out <= '0;
      busy     <= 1'b0;
      avail    <= 1'b0;
      err      <= 1'b0;
    end else begin
      avail <= 1'b0;
      err   <= idle_ok && cs_bad;
      if (state == ST_IDLE) begin
        if (accept) begin
          cpol_q   <= cpol;
          cpha_q   <= cpha;
          lsb_q    <= lsb_first;
          half_q   <= DIV_W'(spi_eff_half(32'(div_factor)));
          sclk     <= cpol;
          cs_n     <= ~(NUM_CS'(1) << cs_sel);
          busy     <= 1'b1;
          // First bit is presented at once; with cpha=1 edge 1 re-drives the same bit.
          mosi     <= tx_word[DATA_W-1];
          tx_sr    <= cpha ? tx_word : (tx_word << 1);
          rx_sr    <= '0;
          edge_cnt <= '0;
        end
      end else begin
        if (tick && shifting) begin
          sclk     <= ~sclk;
          edge_cnt <= edge_cnt + EW'(1);
        end
        if (do_sample) rx_sr <= {rx_sr[DATA_W-2:0], miso};
        if (do_drive) begin
          mosi  <= tx_sr[DATA_W-1];
          tx_sr <= tx_sr << 1;
        end
        if (done) begin
          cs_n     <= '1;
          data_out <= lsb_q ? rev(rx_sr) : rx_sr;
          avail    <= 1'b1;
          busy     <= 1'b0;
          sclk     <= cpol_q;
          mosi     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// tb/tb_spi_master_multi.sv - directed self-checking bench for spi_master_multi
module tb_spi_master_multi;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, cpol, cpha, lsb_first, miso;
  logic [15:0] data_in, div_factor, data_out;
  logic [2:0]  cs_sel;
  logic        mosi, sclk, busy, avail, err;
  logic [3:0]  cs_n;

  int total = 0;
  int bad   = 0;

  logic        loop_en = 1'b1;
  logic        miso_s  = 1'b0;
  logic [15:0] s_word  = 16'h0;
  logic        s_lsb   = 1'b0;
  logic        s_cpha  = 1'b0;
  int          s_idx   = 0;
  int          s_edges = 0;
  logic        s_prev_cs = 1'b0;
  logic        s_prev_sclk = 1'b0;
  logic        cs_act;

  assign miso = loop_en ? mosi : miso_s;

  always #5 clk = ~clk;

  spi_master_multi #(.DATA_W(16), .NUM_CS(4), .DIV_W(16), .CS_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .cs_sel     (cs_sel),
    .cpol       (cpol),
    .cpha       (cpha),
    .lsb_first  (lsb_first),
    .div_factor (div_factor),
    .miso       (miso),
    .mosi       (mosi),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .data_out   (data_out),
    .busy       (busy),
    .avail      (avail),
    .err        (err)
  );

  function automatic logic sbit(input int i);
    logic [15:0] w;
    w = s_word;
    return s_lsb ? w[i] : w[15-i];
  endfunction

  // Slave model: observes the bus mid-cycle, shifts out s_word on its own drive edges.
  always @(negedge clk) begin
    cs_act = (cs_n != 4'hF);
    if (cs_act && !s_prev_cs) begin
      s_idx   = 0;
      s_edges = 0;
      if (!s_cpha) begin
        miso_s = sbit(0);
        s_idx  = 1;
      end
    end else if (cs_act && (sclk != s_prev_sclk)) begin
      s_edges++;
      if (s_cpha ? (s_edges % 2 == 1) : (s_edges % 2 == 0)) begin
        if (s_idx < 16) miso_s = sbit(s_idx);
        s_idx++;
      end
    end
    s_prev_cs   = cs_act;
    s_prev_sclk = sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] d, input logic [2:0] cs, input logic [1:0] mode,
                    input logic lsb, input logic [15:0] div);
    data_in    = d;
    cs_sel     = cs;
    {cpol, cpha} = mode;
    lsb_first  = lsb;
    div_factor = div;
    start      = 1'b1;
    cyc(1);
    start      = 1'b0;
  endtask

  task automatic wait_avail(input int from, input int limit, output int at);
    at = from;
    while (!avail && at < limit) begin
      cyc(1);
      at++;
    end
  endtask

  initial begin
    int   at, edges, first_e, last_e;
    logic prev, busy_ok, mosi_ok, av_seen;

    reset = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    data_in = 16'h0; div_factor = 16'h0; cs_sel = 3'd0;
    cyc(2);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_data", data_out, 0);
    check("rst_avail_err", {avail, err}, 0);
    reset = 1'b1;
    cyc(2);

    // Mode 0, H=2, loopback
    go(16'hA5C3, 3'd0, SPI_MODE0, 1'b0, 16'd2);
    check("m0_cs_n", cs_n, 4'b1110);
    check("m0_busy", busy, 1);
    check("m0_mosi0", mosi, 1);
    edges = 0; first_e = 0; last_e = 0; prev = sclk; busy_ok = 1'b1;
    for (int c = 2; c <= 66; c++) begin
      cyc(1);
      if (sclk !== prev) begin
        edges++;
        if (first_e == 0) first_e = c;
        last_e = c;
      end
      prev = sclk;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check("m0_edges", edges, 32);
    check("m0_first_edge", first_e, 3);
    check("m0_last_edge", last_e, 65);
    check("m0_busy_held", busy_ok, 1);
    cyc(1);
    check("m0_avail", avail, 1);
    check("m0_data", data_out, 16'hA5C3);
    check("m0_busy_end", busy, 0);
    check("m0_cs_end", cs_n, 4'hF);
    cyc(1);
    check("m0_avail_pulse", avail, 0);

    // Mode 3, H=1, slave returns 0x1234 MSB-first
    loop_en = 1'b0; s_word = 16'h1234; s_lsb = 1'b0; s_cpha = 1'b1;
    go(16'hFFFF, 3'd1, SPI_MODE3, 1'b0, 16'd1);
    check("m3_sclk_idle", sclk, 1);
    check("m3_cs_n", cs_n, 4'b1101);
    mosi_ok = (mosi === 1'b1);
    at = 1;
    while (!avail && at < 60) begin
      cyc(1);
      at++;
      if (cs_n != 4'hF && mosi !== 1'b1) mosi_ok = 1'b0;
    end
    check("m3_avail_at", at, 34);
    check("m3_data", data_out, 16'h1234);
    check("m3_mosi_ones", mosi_ok, 1);
    cyc(1);
    check("m3_sclk_end", sclk, 1);

    // Mode 1, LSB-first, H=3, slave returns 0x8000 LSB-first
    s_word = 16'h8000; s_lsb = 1'b1; s_cpha = 1'b1;
    go(16'h0001, 3'd0, SPI_MODE1, 1'b1, 16'd3);
    cyc(3);
    check("lsb_sclk_e1", sclk, 1);
    check("lsb_mosi_e1", mosi, 1);
    cyc(6);
    check("lsb_mosi_e3", mosi, 0);
    wait_avail(10, 150, at);
    check("lsb_avail_at", at, 100);
    check("lsb_data", data_out, 16'h8000);
    cyc(1);

    // cs_sel=2 then invalid cs_sel=5
    loop_en = 1'b1;
    go(16'h5A5A, 3'd2, SPI_MODE0, 1'b0, 16'd1);
    check("cs2_start", cs_n, 4'b1011);
    cyc(9);
    check("cs2_mid", cs_n, 4'b1011);
    wait_avail(10, 60, at);
    check("cs2_avail_at", at, 34);
    check("cs2_data", data_out, 16'h5A5A);
    cyc(1);
    go(16'h1111, 3'd5, SPI_MODE0, 1'b0, 16'd1);
    check("bad_err", err, 1);
    check("bad_cs_n", cs_n, 4'hF);
    check("bad_busy", busy, 0);
    cyc(1);
    check("bad_err_pulse", err, 0);
    check("bad_busy2", busy, 0);

    // start held high through a frame, data_in changed mid-frame
    data_in = 16'h3C96; cs_sel = 3'd3; {cpol, cpha} = SPI_MODE0; lsb_first = 1'b0;
    div_factor = 16'd1; start = 1'b1;
    cyc(1);
    check("hold_busy", busy, 1);
    check("hold_cs", cs_n, 4'b0111);
    cyc(4);
    data_in = 16'h0000;
    wait_avail(5, 60, at);
    check("hold_avail_at", at, 34);
    check("hold_data", data_out, 16'h3C96);
    cyc(1);
    check("hold_no_accept_cs", cs_n, 4'hF);
    check("hold_no_accept_busy", {busy, avail}, 0);
    cyc(1);
    check("hold_second_cs", cs_n, 4'b0111);
    check("hold_second_busy", busy, 1);
    start = 1'b0;
    wait_avail(36, 100, at);
    check("hold2_avail_at", at, 69);
    check("hold2_data", data_out, 16'h0000);
    cyc(1);

    // div_factor=0 runs as H=1
    go(16'hC0DE, 3'd0, SPI_MODE2, 1'b0, 16'd0);
    check("d0_sclk_idle", sclk, 1);
    wait_avail(1, 60, at);
    check("d0_avail_at", at, 34);
    check("d0_data", data_out, 16'hC0DE);
    cyc(2);

    // reset at edge 10 of a frame
    go(16'h1357, 3'd1, SPI_MODE2, 1'b0, 16'd0);
    cyc(10);
    check("rst10_sclk_e10", sclk, 1);
    check("rst10_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("rst10_sclk", sclk, 0);
    check("rst10_mosi", mosi, 0);
    check("rst10_cs_n", cs_n, 4'hF);
    check("rst10_busy_after", busy, 0);
    check("rst10_data", data_out, 0);
    check("rst10_avail_err", {avail, err}, 0);
    cyc(2);
    reset = 1'b1;
    av_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cyc(1);
      if (avail !== 1'b0) av_seen = 1'b1;
    end
    check("rst10_no_avail", av_seen, 0);
    go(16'h0F0F, 3'd1, SPI_MODE0, 1'b0, 16'd2);
    check("post_rst_cs", cs_n, 4'b1101);
    wait_avail(1, 100, at);
    check("post_rst_avail_at", at, 67);
    check("post_rst_data", data_out, 16'h0F0F);
    check("post_rst_cs_end", cs_n, 4'hF);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
